// File: rtl/srv_tcm_loader.sv
// rtl/srv_tcm_loader.sv - boot image loader: packs a byte stream into 64-bit TCM writes and holds the core in reset until the load completes.
module srv_tcm_loader #(
    parameter int AW_TCM = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AW_TCM-1:0] base_addr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [7:0]        s_data,
    input  logic              s_last,
    output logic              tcm_ce,
    output logic              tcm_we,
    output logic [AW_TCM-1:0] tcm_addr,
    output logic [63:0]       tcm_bwe,
    output logic [63:0]       tcm_din,
    output logic              busy,
    output logic              done,
    output logic              core_hold,
    output logic [31:0]       checksum,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t              state, state_next;
    logic [AW_TCM-1:0]   word_addr;
    logic [AW_TCM-1:0]   addr_inc;
    logic [2:0]          byte_idx;
    logic [63:0]         word_data;
    logic [63:0]         word_mask;
    logic                word_last;
    logic                start_ok;
    logic                accept;
    logic                completes;

    assign start_ok  = start && (state == IDLE || state == DONE);
    assign accept    = (state == RECV) && s_valid;
    assign completes = (byte_idx == 3'd7) || s_last;
    assign addr_inc  = word_addr + {{(AW_TCM-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = RECV;
            DONE:    if (start_ok) state_next = RECV;
            RECV:    if (accept && completes) state_next = WRITE;
            WRITE:   state_next = word_last ? DONE : RECV;
            default: state_next = IDLE;
        endcase
    end

    // tcm_addr is a separate register so it keeps the last written address while a new load is armed.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_addr <= '0;
            tcm_addr  <= '0;
            byte_idx  <= 3'd0;
            word_data <= 64'd0;
            word_mask <= 64'd0;
            word_last <= 1'b0;
            checksum  <= 32'd0;
            overflow  <= 1'b0;
        end else if (start_ok) begin
            word_addr <= base_addr;
            byte_idx  <= 3'd0;
            word_data <= 64'd0;
            word_mask <= 64'd0;
            word_last <= 1'b0;
            checksum  <= 32'd0;
            overflow  <= 1'b0;
        end else if (accept) begin
            word_data[8*byte_idx +: 8] <= s_data;
            word_mask[8*byte_idx +: 8] <= 8'hFF;
            byte_idx  <= byte_idx + 3'd1;
            checksum  <= checksum + {24'd0, s_data};
            if (completes) begin
                word_last <= s_last;
                tcm_addr  <= word_addr;
            end
        end else if (state == WRITE) begin
            word_addr <= addr_inc;
            byte_idx  <= 3'd0;
            word_data <= 64'd0;
            word_mask <= 64'd0;
            if (addr_inc == '0 && !word_last) overflow <= 1'b1;
        end
    end

    assign s_ready   = (state == RECV);
    assign tcm_ce    = (state == WRITE);
    assign tcm_we    = (state == WRITE);
    assign tcm_bwe   = (state == WRITE) ? word_mask : 64'd0;
    assign tcm_din   = word_data;
    assign busy      = (state == RECV) || (state == WRITE);
    assign done      = (state == DONE);
    assign core_hold = (state != DONE);

endmodule

// File: tb/tb_srv_tcm_loader.sv
// tb/tb_srv_tcm_loader.sv - directed bench for srv_tcm_loader.
module tb_srv_tcm_loader;

    logic        clk = 1'b0;
    logic        reset, start, s_valid, s_ready, s_last;
    logic [15:0] base_addr, tcm_addr;
    logic [7:0]  s_data;
    logic        tcm_ce, tcm_we, busy, done, core_hold, overflow;
    logic [63:0] tcm_bwe, tcm_din;
    logic [31:0] checksum;

    int n_cmp = 0;
    int n_bad = 0;
    int ready_viol = 0;

    logic [15:0] wq_addr[$];
    logic [63:0] wq_din[$];
    logic [63:0] wq_bwe[$];

    always #5 clk = ~clk;

    srv_tcm_loader #(.AW_TCM(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .tcm_ce(tcm_ce), .tcm_we(tcm_we), .tcm_addr(tcm_addr), .tcm_bwe(tcm_bwe),
        .tcm_din(tcm_din), .busy(busy), .done(done), .core_hold(core_hold),
        .checksum(checksum), .overflow(overflow)
    );

    always @(negedge clk) begin
        if (tcm_ce || tcm_we) begin
            wq_addr.push_back(tcm_addr);
            wq_din.push_back(tcm_din);
            wq_bwe.push_back(tcm_bwe);
            if (s_ready || !tcm_ce || !tcm_we) ready_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_din.delete();
        wq_bwe.delete();
    endtask

    task automatic do_start(input logic [15:0] b);
        start = 1'b1;
        base_addr = b;
        cycle();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        s_valid = 1'b1;
        s_data = d;
        s_last = l;
        n = 0;
        @(negedge clk);
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("send_timeout", 64'd0, 64'd1);
        cycle();
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [15:0] a,
                                input logic [63:0] d, input logic [63:0] m);
        if (wq_addr.size() == 0) begin
            chk({tag, "_present"}, 64'd0, 64'd1);
        end else begin
            chk({tag, "_addr"}, {48'd0, wq_addr.pop_front()}, {48'd0, a});
            chk({tag, "_din"}, wq_din.pop_front(), d);
            chk({tag, "_bwe"}, wq_bwe.pop_front(), m);
        end
    endtask

    logic [7:0]  bytes[24];
    logic [63:0] w;
    logic [31:0] sum;

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        cycle(); cycle();
        reset = 1'b0;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ce", tcm_ce, 0);
        chk("rst_we", tcm_we, 0);
        chk("rst_addr", tcm_addr, 0);
        chk("rst_bwe", tcm_bwe, 0);
        chk("rst_din", tcm_din, 0);
        chk("rst_busy_done", {busy, done}, 0);
        chk("rst_core_hold", core_hold, 1);
        chk("rst_checksum", checksum, 0);
        chk("rst_overflow", overflow, 0);

        // basic word
        clear_writes();
        do_start(16'h0010);
        chk("basic_ready_after_start", s_ready, 1);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        chk("basic_write_ce", tcm_ce, 1);
        chk("basic_ready_in_write", s_ready, 0);
        chk("basic_hold_in_write", {done, core_hold}, 2'b01);
        cycle();
        chk("basic_done", done, 1);
        chk("basic_core_hold", core_hold, 0);
        chk("basic_checksum", checksum, 32'h24);
        expect_write("basic", 16'h0010, 64'h0807060504030201, {64{1'b1}});
        chk("basic_nwrites", wq_addr.size(), 0);

        // partial tail
        clear_writes();
        do_start(16'h0020);
        for (int i = 0; i < 11; i++) send_byte(8'(8'hA0 + i), i == 10);
        cycle();
        chk("tail_done", done, 1);
        chk("tail_checksum", checksum, 32'h717);
        expect_write("tail0", 16'h0020, 64'hA7A6A5A4A3A2A1A0, {64{1'b1}});
        expect_write("tail1", 16'h0021, 64'h0000000000AAA9A8, 64'h0000000000FFFFFF);

        // backpressure and gaps
        clear_writes();
        ready_viol = 0;
        sum = 0;
        do_start(16'h0040);
        for (int i = 0; i < 24; i++) begin
            bytes[i] = 8'(i * 7 + 3);
            sum += {24'd0, bytes[i]};
            repeat ($urandom_range(0, 3)) cycle();
            send_byte(bytes[i], i == 23);
        end
        cycle();
        chk("bp_done", done, 1);
        chk("bp_checksum", checksum, sum);
        chk("bp_ready_low_in_write", ready_viol, 0);
        chk("bp_nwrites", wq_addr.size(), 3);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 8; j++) w[8*j +: 8] = bytes[8*k + j];
            expect_write($sformatf("bp%0d", k), 16'(16'h0040 + k), w, {64{1'b1}});
        end

        // wrap
        clear_writes();
        do_start(16'hFFFF);
        chk("wrap_ovf_cleared", overflow, 0);
        for (int i = 0; i < 16; i++) send_byte(8'(i), i == 15);
        cycle();
        chk("wrap_overflow", overflow, 1);
        chk("wrap_done", done, 1);
        expect_write("wrap0", 16'hFFFF, 64'h0706050403020100, {64{1'b1}});
        expect_write("wrap1", 16'h0000, 64'h0F0E0D0C0B0A0908, {64{1'b1}});

        // reset mid-load
        clear_writes();
        do_start(16'h0080);
        chk("mid_ovf_cleared", overflow, 0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h50 + i), 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid_ready", s_ready, 0);
        chk("mid_busy_done", {busy, done}, 0);
        chk("mid_core_hold", core_hold, 1);
        chk("mid_checksum", checksum, 0);
        chk("mid_din", tcm_din, 0);
        chk("mid_addr", tcm_addr, 0);
        cycle(); cycle();
        chk("mid_no_write", wq_addr.size(), 0);

        // reload from DONE, with a stray start during RECV
        do_start(16'h0200);
        send_byte(8'h5A, 1'b1);
        cycle();
        chk("pre_reload_done", done, 1);
        expect_write("single", 16'h0200, 64'h5A, 64'hFF);
        clear_writes();
        do_start(16'h0100);
        chk("reload_done", done, 0);
        chk("reload_core_hold", core_hold, 1);
        chk("reload_checksum", checksum, 0);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0);
        do_start(16'h0300);
        chk("reload_ignore_start_ready", s_ready, 1);
        chk("reload_ignore_start_sum", checksum, 32'h66);
        for (int i = 3; i < 8; i++) send_byte(8'(8'h11 * (i + 1)), i == 7);
        cycle();
        chk("reload_done_end", done, 1);
        chk("reload_checksum_end", checksum, 32'h264);
        expect_write("reload", 16'h0100, 64'h8877665544332211, {64{1'b1}});
        chk("reload_nwrites", wq_addr.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/srv_tcm_loader.md
# srv_tcm_loader

Boot-time image loader that writes a byte stream into a 64-bit single-port TCM and holds the core in reset until the image is resident. It sits between an external byte source (UART/JTAG/flash bridge) and the ITCM or DTCM SRAM port, alongside `srv_core`. It packs bytes little-endian into 64-bit words and issues byte-masked SRAM writes. It also reports a running checksum and an overflow flag.

## Interface
Parameters:
- AW_TCM, 16, TCM word-address width; the TCM holds 2**AW_TCM 64-bit words.

Ports:
- clk  in  1  single clock; all logic rises on posedge clk.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- base_addr  in  AW_TCM  first word address; sampled on the accepted start.
- s_valid  in  1  byte-stream valid.
- s_ready  out  1  byte-stream ready.
- s_data  in  8  stream byte.
- s_last  in  1  marks the final byte of the image; qualified by s_valid & s_ready.
- tcm_ce  out  1  SRAM chip enable.
- tcm_we  out  1  SRAM write enable.
- tcm_addr  out  AW_TCM  SRAM word address.
- tcm_bwe  out  64  SRAM bit-write enable; each lane is 8 bits.
- tcm_din  out  64  SRAM write data.
- busy  out  1  high in RECV or WRITE.
- done  out  1  high in DONE.
- core_hold  out  1  active-high reset request to the core; low only in DONE.
- checksum  out  32  sum of all accepted bytes mod 2**32 for the current load.
- overflow  out  1  sticky; set when the word address wraps during a load.

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE → RECV on start.
- DONE → RECV on start.
- RECV → WRITE when the 8th byte of a word is accepted, or when a byte with s_last is accepted.
- WRITE → RECV after one cycle if the word was not last.
- WRITE → DONE after one cycle if the word was last.
- On an accepted start:
  - load addr ← base_addr;
  - clear the byte index, checksum and overflow;
  - clear done; set core_hold.
- start is ignored in RECV and WRITE.
- s_ready is 1 only in RECV; it is 0 in IDLE, WRITE and DONE.
- Byte k (0..7) of a word goes to tcm_din[8k+7:8k] and sets tcm_bwe[8k+7:8k] to all ones.
- Unfilled lanes of a partial final word have bwe = 0 and din = 0.
- The checksum adds each accepted byte, zero-extended, and wraps mod 2**32.
- WRITE lasts exactly one cycle with tcm_ce = tcm_we = 1 and tcm_addr = current word address.
- After WRITE the word address increments mod 2**AW_TCM, then the byte index, din and bwe clear.
- If the increment wraps to 0 and the word just written was not last, overflow is set. The load continues and overwrites from address 0.
- tcm_ce, tcm_we and tcm_bwe are 0 outside WRITE.
- tcm_addr holds its last value outside WRITE.
- The loader never reads the TCM; tcm_dout is not an input.
- Reset mid-operation returns to IDLE at the next edge. A pending partial word is discarded and no write is issued.

## Timing
- Reset values:
  - state IDLE;
  - s_ready 0, tcm_ce 0, tcm_we 0;
  - tcm_addr 0, tcm_bwe 0, tcm_din 0;
  - busy 0, done 0;
  - core_hold 1;
  - checksum 0, overflow 0.
- start at edge E: RECV and s_ready = 1 from E+1.
- Completing byte accepted at edge A: write asserted for the cycle A..A+1, and the SRAM captures at A+1.
- The completing byte is the 8th byte of a word or the s_last byte.
- After the last word, done = 1 and core_hold = 0 from A+1 onward.
- Peak throughput is 8 bytes per 9 cycles, because s_ready drops for the WRITE cycle.
- checksum updates on the edge that accepts the byte.
- overflow updates on the edge that ends WRITE.

## Test plan
- Basic word: base 0x0010, bytes 0x01..0x08, last on 0x08 → one write:
  - addr 0x0010, din 0x0807060504030201, bwe all ones;
  - done = 1 and core_hold = 0 on the next edge;
  - checksum 0x24.
- Partial tail: base 0x0020, 11 bytes 0xA0..0xAA → two writes:
  - first write: addr 0x0020, full bwe;
  - second write: addr 0x0021, bwe 0x0000000000FFFFFF, din 0x0000000000AAA9A8.
- Backpressure and gaps: random s_valid gaps over 24 bytes → s_ready = 0 exactly in each WRITE cycle, no byte lost or duplicated, 3 full writes.
- Wrap: base 0xFFFF, 16 bytes → writes at 0xFFFF then 0x0000, overflow = 1, done = 1.
- Reset mid-load: assert reset after 5 bytes → no tcm_ce pulse, all outputs at reset values the next cycle, core_hold = 1.
- Reload: start in DONE with base 0x0100 → done = 0, core_hold = 1, checksum = 0 the next cycle; an 8-byte image writes at 0x0100. start pulsed during RECV is ignored.
